gesture_frame_classifier: RTL and testbench
===========================================

// Module: gesture_frame_classifier
// PURPOSE
//  Frame-based, debounced successor to the single-sample gesture recognizer.
//  - Tracks the peak fingertip metric over each video frame, delimited by VS rising edges.
//  - Maps the peak into one of NUM_BANDS parametrised value bands.
//  - Commits a new command code only after DEBOUNCE consecutive frames agree.
//  - Sits between the contour/fingertip measurement stage and the motor-command UART/driver.
// PARAMETERS
//  DATA_W    20                          width of fingertip_data
//  RES_W     8                           width of result code
//  NUM_BANDS 3                           number of gesture bands
//  BAND_LO   {20'd0,20'd221,20'd301}     packed NUM_BANDS*DATA_W lower bounds, band0 in LSBs
//  BAND_HI   {20'd199,20'd279,20'hFFFFF} packed NUM_BANDS*DATA_W upper bounds, inclusive
//  DEBOUNCE  4                           consecutive equal frames needed to commit (>=1)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous reset, active-high
//  en             in   1          fingertip_data valid this cycle
//  VS             in   1          frame sync; a rising edge ends the current frame
//  fingertip_data in   DATA_W     fingertip metric sample
//  raw_cls        out  RES_W      undebounced class of the last completed frame
//  raw_vld        out  1          1-cycle pulse when raw_cls updates
//  result         out  RES_W      committed command code (0 = none/stop)
//  result_vld     out  1          1-cycle pulse when result changes value
// BEHAVIOUR
//  Clock and reset:
//  - One clock, clk. Reset rst is synchronous and active-high.
//  - On rst: all outputs = 0, peak = 0, have_sample = 0, run counter = 0, FSM -> SYNC.
//  - rst asserted mid-frame discards the partial frame; nothing is emitted.
//  Edge detection:
//  - vs_d is VS registered once. edge = VS & ~vs_d.
//  FSM states and transitions:
//  - SYNC: wait for the first edge, then go to ACCUM. Data before the first edge is ignored.
//  - ACCUM: on en, peak <= max(peak, fingertip_data) and have_sample <= 1.
//    - On edge, go to CLASS. An en sample in the edge cycle belongs to the ending frame.
//  - CLASS: one cycle.
//    - cls = (i+1) for the lowest i with BAND_LO[i] <= peak <= BAND_HI[i].
//    - cls = 0 if no band matches or have_sample == 0.
//    - raw_cls <= cls and raw_vld <= 1.
//    - Clear peak and have_sample. Go to ACCUM.
//    - Samples with en in the CLASS cycle start the new frame and are accumulated.
//    - An edge in the CLASS cycle (frame of 1 cycle) is honoured: go to CLASS again next cycle.
//  Debounce (evaluated in the cycle after raw_vld):
//  - If raw_cls == cand: run = min(run+1, DEBOUNCE). Otherwise cand <= raw_cls and run <= 1.
//  - When run reaches DEBOUNCE and cand != result: result <= cand, result_vld <= 1.
//  - With DEBOUNCE = 1 the first frame commits.
//  - Class 0 is debounced like any other class, so a hand removed for DEBOUNCE frames gives result 0.
//  Latency:
//  - VS rise at input in cycle t, vs_d sees it at t+1.
//  - raw_vld at t+2. result_vld at t+3.
//  Arithmetic and width:
//  - peak is DATA_W bits; compares are unsigned; no overflow is possible.
//  - run counter is $clog2(DEBOUNCE+1) bits and saturates at DEBOUNCE.
//  - Overlapping bands resolve by lowest index. Gaps between bands map to 0.
//  Held signals:
//  - VS held high does not retrigger; only rising edges count.
//  - en held high for the whole frame is legal.
// STRUCTURE
//  Shared package gesture_pkg:
//  - GEST_NONE=0, GEST_FWD, GEST_BACK, GEST_LEFT codes.
//  - Default band bound constants, RES_W.
//  Sub-module gesture_band_lut:
//  - Combinational; peak + BAND_LO/BAND_HI -> cls, using a priority loop over NUM_BANDS.
//  - Reused by later multi-channel variants.
//  Top-level contents:
//  - VS edge detector, peak accumulator, 3-state FSM, debounce counter, output registers.
// TESTING
//  1. Reset: rst high 3 cycles during VS toggling -> all outputs 0. No raw_vld until the second VS edge after release.
//  2. Band mapping, DEBOUNCE=1:
//     - frames with peak 350, 250, 100 -> raw_cls/result 1, 2, 3.
//     - peak 210 -> result 0.
//     - band edges: 300 -> 0, 301 -> 1, 220 -> 0, 279 -> 2, 199 -> 3.
//  3. Peak tracking: one frame with samples 100, 320, 150 -> raw_cls=1. Empty frame (no en) -> raw_cls=0.
//  4. Debounce, DEBOUNCE=4:
//     - classes 1,1,1,2,1,1,1,1 -> single result_vld, result=1, on the 8th frame.
//     - run saturates and no repeat pulse on further 1s.
//  5. Boundary timing:
//     - en sample 400 in the VS edge cycle counts toward the ending frame.
//     - edge in the CLASS cycle gives two back-to-back raw_vld.
//     - latency t+2 / t+3 checked.
//  6. rst mid-frame after samples of 350 -> no raw_vld for that frame. result stays 0 until DEBOUNCE new frames.

Source files
------------

// File: rtl/gesture_frame_classifier_pkg.sv
// Shared definitions for the gesture frame classifier family: result codes,
// FSM state encoding and the default band table.
package gesture_frame_classifier_pkg;

  localparam int DATA_W_DEF    = 20;
  localparam int RES_W_DEF     = 8;
  localparam int NUM_BANDS_DEF = 3;
  localparam int DEBOUNCE_DEF  = 4;

  // Band table, band 0 in the least significant slice. Bounds are inclusive.
  // band0: 301..max -> code 1, band1: 221..279 -> code 2, band2: 0..199 -> code 3
  localparam logic [NUM_BANDS_DEF*DATA_W_DEF-1:0] BAND_LO_DEF =
    {20'd0, 20'd221, 20'd301};
  localparam logic [NUM_BANDS_DEF*DATA_W_DEF-1:0] BAND_HI_DEF =
    {20'd199, 20'd279, 20'hFFFFF};

  // Command codes handed to the motor driver; 0 means stop / no gesture.
  typedef enum logic [RES_W_DEF-1:0] {
    GEST_NONE = 8'd0,
    GEST_FWD  = 8'd1,
    GEST_BACK = 8'd2,
    GEST_LEFT = 8'd3
  } gest_e;

  // Frame-tracking FSM states.
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CLASS = 2'd2
  } state_e;

endpackage

// File: rtl/gesture_frame_classifier_if.sv
// Measurement-stage bus into the classifier and the classified outputs back.
// master = producer of fingertip samples, slave = classifier.
interface gesture_frame_classifier_if
  import gesture_frame_classifier_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
);

  logic              en;
  logic              VS;
  logic [DATA_W-1:0] fingertip_data;
  logic [RES_W-1:0]  raw_cls;
  logic              raw_vld;
  logic [RES_W-1:0]  result;
  logic              result_vld;

  modport master (
    output en, VS, fingertip_data,
    input  raw_cls, raw_vld, result, result_vld
  );

  modport slave (
    input  en, VS, fingertip_data,
    output raw_cls, raw_vld, result, result_vld
  );

endinterface

// File: rtl/gesture_frame_classifier_band_lut.sv
// Combinational band lookup: maps a frame peak onto a class code.
// Lowest matching band index wins; no match or an empty frame gives 0.
module gesture_frame_classifier_band_lut
  import gesture_frame_classifier_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int NUM_BANDS = NUM_BANDS_DEF,
  parameter logic [NUM_BANDS*DATA_W-1:0] BAND_LO = BAND_LO_DEF,
  parameter logic [NUM_BANDS*DATA_W-1:0] BAND_HI = BAND_HI_DEF
) (
  input  logic [DATA_W-1:0] peak,
  input  logic              have_sample,
  output logic [RES_W-1:0]  cls
);

  // Walk bands from highest to lowest index so the lowest match is the last write.
  always_comb begin
    cls = {RES_W{1'b0}};
    for (int i = NUM_BANDS - 32'sd1; i >= 32'sd0; i--) begin
      if (have_sample &&
          (peak >= BAND_LO[i*DATA_W +: DATA_W]) &&
          (peak <= BAND_HI[i*DATA_W +: DATA_W])) begin
        cls = RES_W'(i + 32'sd1);
      end else begin
        cls = cls;
      end
    end
  end

endmodule

// File: rtl/gesture_frame_classifier.sv
// Frame-based gesture classifier: tracks the peak fingertip metric per VS
// frame, classifies it into a band and commits a command code only after
// DEBOUNCE consecutive frames agree.
module gesture_frame_classifier
  import gesture_frame_classifier_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int NUM_BANDS = NUM_BANDS_DEF,
  parameter logic [NUM_BANDS*DATA_W-1:0] BAND_LO = BAND_LO_DEF,
  parameter logic [NUM_BANDS*DATA_W-1:0] BAND_HI = BAND_HI_DEF,
  parameter int DEBOUNCE  = DEBOUNCE_DEF
) (
  input logic clk,
  input logic rst,
  gesture_frame_classifier_if.slave bus
);

  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(32'd1);

  state_e            state_q, state_d;
  logic              vs_q, vs_d;
  logic              vs_edge_s;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              have_q, have_d;
  logic [RES_W-1:0]  cls_s;
  logic [RES_W-1:0]  raw_cls_q, raw_cls_d;
  logic              raw_vld_q, raw_vld_d;
  logic [RES_W-1:0]  cand_q, cand_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              result_vld_q, result_vld_d;

  // vs_q is VS delayed one cycle; it keeps tracking VS through reset so a VS
  // held high across reset release is not mistaken for a new frame edge.
  assign vs_d      = bus.VS;
  assign vs_edge_s = bus.VS & ~vs_q;

  gesture_frame_classifier_band_lut #(
    .DATA_W   (DATA_W),
    .RES_W    (RES_W),
    .NUM_BANDS(NUM_BANDS),
    .BAND_LO  (BAND_LO),
    .BAND_HI  (BAND_HI)
  ) u_band_lut (
    .peak       (peak_q),
    .have_sample(have_q),
    .cls        (cls_s)
  );

  // Frame FSM: sync to the first edge, accumulate the peak, classify on edges.
  always_comb begin
    state_d   = state_q;
    peak_d    = peak_q;
    have_d    = have_q;
    raw_cls_d = raw_cls_q;
    raw_vld_d = 1'b0;
    case (state_q)
      ST_SYNC: begin
        // Samples before the first edge belong to no complete frame.
        if (vs_edge_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_ACCUM: begin
        // A sample in the edge cycle still belongs to the frame that ends.
        if (bus.en && (bus.fingertip_data > peak_q)) begin
          peak_d = bus.fingertip_data;
        end else begin
          peak_d = peak_q;
        end
        if (bus.en) begin
          have_d = 1'b1;
        end else begin
          have_d = have_q;
        end
        if (vs_edge_s) begin
          state_d = ST_CLASS;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_CLASS: begin
        raw_cls_d = cls_s;
        raw_vld_d = 1'b1;
        // The classify cycle is already the first cycle of the next frame.
        if (bus.en) begin
          peak_d = bus.fingertip_data;
          have_d = 1'b1;
        end else begin
          peak_d = {DATA_W{1'b0}};
          have_d = 1'b0;
        end
        if (vs_edge_s) begin
          state_d = ST_CLASS;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_SYNC;
        peak_d  = {DATA_W{1'b0}};
        have_d  = 1'b0;
      end
    endcase
  end

  // Debounce: count consecutive equal frame classes, commit on a full run.
  always_comb begin
    cand_d       = cand_q;
    run_d        = run_q;
    result_d     = result_q;
    result_vld_d = 1'b0;
    if (raw_vld_q) begin
      if (raw_cls_q == cand_q) begin
        if (run_q == RUN_MAX) begin
          run_d = run_q;
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end else begin
        cand_d = raw_cls_q;
        run_d  = RUN_ONE;
      end
      // Only a change of committed value produces a pulse.
      if ((run_d == RUN_MAX) && (cand_d != result_q)) begin
        result_d     = cand_d;
        result_vld_d = 1'b1;
      end else begin
        result_d = result_q;
      end
    end else begin
      cand_d = cand_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    vs_q <= vs_d;
    if (rst) begin
      state_q      <= ST_SYNC;
      peak_q       <= {DATA_W{1'b0}};
      have_q       <= 1'b0;
      raw_cls_q    <= {RES_W{1'b0}};
      raw_vld_q    <= 1'b0;
      cand_q       <= {RES_W{1'b0}};
      run_q        <= {RUN_W{1'b0}};
      result_q     <= {RES_W{1'b0}};
      result_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      peak_q       <= peak_d;
      have_q       <= have_d;
      raw_cls_q    <= raw_cls_d;
      raw_vld_q    <= raw_vld_d;
      cand_q       <= cand_d;
      run_q        <= run_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
    end
  end

  assign bus.raw_cls    = raw_cls_q;
  assign bus.raw_vld    = raw_vld_q;
  assign bus.result     = result_q;
  assign bus.result_vld = result_vld_q;

endmodule

// File: tb/tb_gesture_frame_classifier.sv
// Directed bench: one classifier with DEBOUNCE=1 (band mapping, peak
// tracking) and one with DEBOUNCE=4 (debounce, boundary timing, reset).
module tb_gesture_frame_classifier;

  logic        clk;
  logic        rst;
  logic        sel;      // 0 drives dut_d1, 1 drives dut_d4
  logic        vs_b;
  logic        en_b;
  logic [19:0] data_b;

  int n_checks;
  int n_pass;

  gesture_frame_classifier_if #(.DATA_W(20), .RES_W(8)) if_d1 ();
  gesture_frame_classifier_if #(.DATA_W(20), .RES_W(8)) if_d4 ();

  assign if_d1.VS             = (sel == 1'b0) ? vs_b : 1'b0;
  assign if_d1.en             = (sel == 1'b0) ? en_b : 1'b0;
  assign if_d1.fingertip_data = data_b;
  assign if_d4.VS             = (sel == 1'b1) ? vs_b : 1'b0;
  assign if_d4.en             = (sel == 1'b1) ? en_b : 1'b0;
  assign if_d4.fingertip_data = data_b;

  gesture_frame_classifier #(.DEBOUNCE(1)) dut_d1 (
    .clk(clk), .rst(rst), .bus(if_d1)
  );

  gesture_frame_classifier #(.DEBOUNCE(4)) dut_d4 (
    .clk(clk), .rst(rst), .bus(if_d4)
  );

  logic [7:0] o_raw_cls;
  logic       o_raw_vld;
  logic [7:0] o_result;
  logic       o_result_vld;

  assign o_raw_cls    = sel ? if_d4.raw_cls    : if_d1.raw_cls;
  assign o_raw_vld    = sel ? if_d4.raw_vld    : if_d1.raw_vld;
  assign o_result     = sel ? if_d4.result     : if_d1.result;
  assign o_result_vld = sel ? if_d4.result_vld : if_d1.result_vld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_vld(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (o_raw_vld) cnt++;
    end
  endtask

  // One frame of n samples followed by a VS edge; checks the t+1/t+2/t+3 timing.
  task automatic do_frame(input string tag, input int n,
                          input logic [19:0] s0, input logic [19:0] s1, input logic [19:0] s2,
                          input int exp_raw, input int exp_res, input int exp_rvld);
    logic [19:0] s [3];
    s[0] = s0; s[1] = s1; s[2] = s2;
    for (int k = 0; k < n; k++) begin
      en_b = 1'b1; data_b = s[k];
      tick();
    end
    en_b = 1'b0; data_b = 20'd0;
    vs_b = 1'b1;
    tick();
    vs_b = 1'b0;
    chk({tag, "_vld_t1"}, o_raw_vld, 1'b0);
    tick();
    chk({tag, "_vld_t2"}, o_raw_vld, 1'b1);
    chk({tag, "_raw"}, o_raw_cls, exp_raw);
    chk({tag, "_rvld_t2"}, o_result_vld, 1'b0);
    tick();
    chk({tag, "_vld_t3"}, o_raw_vld, 1'b0);
    chk({tag, "_rvld_t3"}, o_result_vld, exp_rvld);
    chk({tag, "_res"}, o_result, exp_res);
  endtask

  initial begin
    int c1;
    int c2;
    n_checks = 0; n_pass = 0;
    sel = 1'b0; vs_b = 1'b0; en_b = 1'b0; data_b = 20'd0;

    // 1. reset with VS toggling
    rst = 1'b1;
    vs_b = 1'b1; tick();
    vs_b = 1'b0; tick();
    vs_b = 1'b1; tick();
    rst = 1'b0; vs_b = 1'b0;
    chk("rst_d1_raw_cls", if_d1.raw_cls, 8'd0);
    chk("rst_d1_raw_vld", if_d1.raw_vld, 1'b0);
    chk("rst_d1_result", if_d1.result, 8'd0);
    chk("rst_d1_result_vld", if_d1.result_vld, 1'b0);
    chk("rst_d4_raw_cls", if_d4.raw_cls, 8'd0);
    chk("rst_d4_raw_vld", if_d4.raw_vld, 1'b0);
    chk("rst_d4_result", if_d4.result, 8'd0);
    chk("rst_d4_result_vld", if_d4.result_vld, 1'b0);
    tick();
    vs_b = 1'b1;
    count_vld(1, c1);
    vs_b = 1'b0;
    count_vld(4, c2);
    chk("first_edge_no_vld", c1 + c2, 0);

    // 2. band mapping, DEBOUNCE=1
    do_frame("b350", 1, 20'd350, 20'd0, 20'd0, 1, 1, 1);
    do_frame("b250", 1, 20'd250, 20'd0, 20'd0, 2, 2, 1);
    do_frame("b100", 1, 20'd100, 20'd0, 20'd0, 3, 3, 1);
    do_frame("b210", 1, 20'd210, 20'd0, 20'd0, 0, 0, 1);
    do_frame("b300", 1, 20'd300, 20'd0, 20'd0, 0, 0, 0);
    do_frame("b301", 1, 20'd301, 20'd0, 20'd0, 1, 1, 1);
    do_frame("b220", 1, 20'd220, 20'd0, 20'd0, 0, 0, 1);
    do_frame("b279", 1, 20'd279, 20'd0, 20'd0, 2, 2, 1);
    do_frame("b199", 1, 20'd199, 20'd0, 20'd0, 3, 3, 1);

    // 3. peak tracking and empty frame
    do_frame("peak3", 3, 20'd100, 20'd320, 20'd150, 1, 1, 1);
    do_frame("empty", 0, 20'd0, 20'd0, 20'd0, 0, 0, 1);

    // 4. debounce on DEBOUNCE=4 instance; first edge only syncs it
    sel = 1'b1;
    tick();
    vs_b = 1'b1; tick();
    vs_b = 1'b0; tick(); tick();
    do_frame("db1", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("db2", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("db3", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("db4", 1, 20'd250, 20'd0, 20'd0, 2, 0, 0);
    do_frame("db5", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("db6", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("db7", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("db8", 1, 20'd350, 20'd0, 20'd0, 1, 1, 1);
    do_frame("db9", 1, 20'd350, 20'd0, 20'd0, 1, 1, 0);
    do_frame("db10", 1, 20'd350, 20'd0, 20'd0, 1, 1, 0);

    // 5a. sample in the edge cycle belongs to the ending frame
    en_b = 1'b1; data_b = 20'd100; tick();
    data_b = 20'd400; vs_b = 1'b1; tick();
    en_b = 1'b0; data_b = 20'd0; vs_b = 1'b0;
    chk("edge_smp_vld_t1", o_raw_vld, 1'b0);
    tick();
    chk("edge_smp_vld_t2", o_raw_vld, 1'b1);
    chk("edge_smp_raw", o_raw_cls, 8'd1);
    tick();
    chk("edge_smp_rvld", o_result_vld, 1'b0);
    chk("edge_smp_res", o_result, 8'd1);

    // 5b. fastest frame pair; sample in the classify cycle starts the new frame
    en_b = 1'b1; data_b = 20'd100; vs_b = 1'b1; tick();
    data_b = 20'd250; vs_b = 1'b0; tick();
    chk("pair_vld_a", o_raw_vld, 1'b1);
    chk("pair_raw_a", o_raw_cls, 8'd3);
    en_b = 1'b0; data_b = 20'd0; vs_b = 1'b1; tick();
    vs_b = 1'b0;
    chk("pair_gap", o_raw_vld, 1'b0);
    tick();
    chk("pair_vld_b", o_raw_vld, 1'b1);
    chk("pair_raw_b", o_raw_cls, 8'd2);
    tick();
    chk("pair_res", o_result, 8'd1);

    // 5c. commit latency on DEBOUNCE=4
    do_frame("lat1", 1, 20'd100, 20'd0, 20'd0, 3, 1, 0);
    do_frame("lat2", 1, 20'd100, 20'd0, 20'd0, 3, 1, 0);
    do_frame("lat3", 1, 20'd100, 20'd0, 20'd0, 3, 1, 0);
    do_frame("lat4", 1, 20'd100, 20'd0, 20'd0, 3, 3, 1);

    // 6. reset mid-frame discards the partial frame
    en_b = 1'b1; data_b = 20'd350; tick();
    en_b = 1'b0; data_b = 20'd0; rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_rst_res", o_result, 8'd0);
    chk("mid_rst_vld", o_raw_vld, 1'b0);
    vs_b = 1'b1;
    count_vld(1, c1);
    vs_b = 1'b0;
    count_vld(4, c2);
    chk("mid_rst_no_vld", c1 + c2, 0);
    do_frame("pr1", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("pr2", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("pr3", 1, 20'd350, 20'd0, 20'd0, 1, 0, 0);
    do_frame("pr4", 1, 20'd350, 20'd0, 20'd0, 1, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
